fft_stage_ctrl: RTL and testbench
=================================

// Module: fft_stage_ctrl
// PURPOSE
//  Sequences the in-place radix-2 DIT butterfly passes of the multi-mode FFT (N = 64/128/256/512).
//  Starts on the one-cycle resort-complete pulse, once bit-reversed input sits in the work RAM.
//  Per stage, issues N/2 butterfly read-address pairs plus a twiddle ROM address.
//  Issues the matching write-back pairs BF_LAT cycles later, then signals done.
//  Sits between the input resort stage, the work RAM, the twiddle ROM and the butterfly pipe.
// PARAMETERS
//  ADDR_W     9   work-RAM address width (max N = 512)
//  TW_W       8   twiddle ROM address width (256-entry table, sized for N = 512)
//  BF_LAT     4   butterfly read-to-write latency in cycles; legal range 1..15
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       one-cycle pulse: resort complete, begin FFT passes
//  N          in   10      transform size; sampled only in the cycle start is accepted
//  rd_en      out  1       butterfly read strobe
//  rd_addr_a  out  ADDR_W  upper butterfly input address
//  rd_addr_b  out  ADDR_W  lower butterfly input address
//  tw_addr    out  TW_W    twiddle ROM address, aligned with rd_en
//  wr_en      out  1       write-back strobe (rd_en delayed BF_LAT cycles)
//  wr_addr_a  out  ADDR_W  write-back address A
//  wr_addr_b  out  ADDR_W  write-back address B
//  stage      out  4       current stage index 0..log2N-1
//  busy       out  1       high from start acceptance until done
//  done       out  1       one-cycle pulse after the final write-back
//  cfg_err    out  1       one-cycle pulse: start received with an illegal N
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, write pipe cleared.
//  Reset mid-operation aborts immediately; no done pulse is produced.
//  FSM: IDLE -> LOAD -> RUN -> DRAIN -> (RUN | FIN) -> IDLE.
//   IDLE : start with N in {64,128,256,512} -> LOAD; latch L = log2N; busy <= 1.
//          start with any other N -> cfg_err pulse next cycle; stay IDLE.
//   LOAD : clear stage, b; go to RUN. Single cycle.
//   RUN  : rd_en = 1 each cycle; b counts 0..N/2-1; at b = N/2-1 go to DRAIN.
//   DRAIN: rd_en = 0 for exactly BF_LAT cycles (RAW guard).
//          Then go to RUN with stage+1, or to FIN if stage = L-1.
//   FIN  : done <= 1, busy <= 0; return to IDLE. One cycle.
//  start while busy is ignored (no error, no restart).
//  Address generation, with span = 1<<stage and pos = b & (span-1):
//   rd_addr_a = ((b >> stage) << (stage+1)) | pos
//   rd_addr_b = rd_addr_a + span
//   tw_addr   = pos << (TW_W - stage)
//   tw_addr is independent of N because the table is fixed for 512 points.
//  All address outputs are registered and valid only while rd_en = 1; otherwise held at 0.
//  Write pipe: BF_LAT-deep shift register of {rd_en, rd_addr_a, rd_addr_b}.
//   wr_* equal rd_* delayed exactly BF_LAT cycles.
//  Timing, with start accepted at cycle 0:
//   first rd_en at cycle 2;
//   each stage occupies N/2 + BF_LAT cycles;
//   done at cycle 2 + L*(N/2 + BF_LAT).
//  No cycle ever carries rd_en while wr_en targets an address of the same stage's pending pair.
//   The DRAIN gap guarantees this.
// STRUCTURE
//  Shared package fft_pkg holds:
//   N_64/N_128/N_256/N_512 constants, ADDR_W, TW_W,
//   a log2N() function (returns 0 for illegal N),
//   state encoding localparams.
//  One natural sub-module: fft_bf_addr_gen.
//   Combinational {stage, b} -> {addr_a, addr_b, tw_addr}; registered in the parent.
//  The delay line stays inline in the parent.
// TESTING
//  N=64, BF_LAT=4, start @0:
//   rd_en high cycles 2..33;
//   stage0 pairs (0,1),(2,3)..; done @218; exactly 192 wr_en cycles.
//  N=512:
//   stage 8 first pair (0,256) tw 0; second pair (1,257) tw 1;
//   stage 0 every tw_addr = 0; done @2+9*260 = 2342.
//  start with N=100:
//   cfg_err pulse @1; busy, rd_en, done stay 0.
//  Second start pulse while busy:
//   ignored; done count and cycle unchanged.
//  rst_n low mid-stage 3:
//   all outputs 0 asynchronously; no done;
//   next start runs a full, correct sequence.
//  Scoreboard, all four N:
//   every index 0..N-1 read and written exactly once per stage;
//   wr_addr equals rd_addr delayed BF_LAT cycles.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, state encoding and helpers for the FFT butterfly
// stage controller.
package fft_pkg;

  localparam int ADDR_W = 9;
  localparam int TW_W   = 8;

  localparam logic [9:0] N_64  = 10'd64;
  localparam logic [9:0] N_128 = 10'd128;
  localparam logic [9:0] N_256 = 10'd256;
  localparam logic [9:0] N_512 = 10'd512;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_FIN   = ST_FIN
  } state_e;

  // Zero marks an unsupported transform size.
  function automatic logic [3:0] log2N(input logic [9:0] n);
    case (n)
      N_64:    return 4'd6;
      N_128:   return 4'd7;
      N_256:   return 4'd8;
      N_512:   return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Combinational butterfly pair and twiddle address generator for one
// {stage, butterfly index} point of an in-place radix-2 DIT pass.
module fft_bf_addr_gen #(
  parameter int ADDR_W = fft_pkg::ADDR_W,
  parameter int TW_W   = fft_pkg::TW_W
) (
  input  logic [3:0]        stage,
  input  logic [ADDR_W-1:0] b,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [TW_W-1:0]   tw_addr
);

  logic [ADDR_W-1:0]      span;
  logic [ADDR_W-1:0]      pos;
  logic [ADDR_W-1:0]      grp;
  logic [ADDR_W+TW_W-1:0] tw_w;

  always_comb begin
    span    = ADDR_W'(1) << stage;
    pos     = b & (span - ADDR_W'(1));
    grp     = (b >> stage) << (stage + 4'd1);
    addr_a  = grp | pos;
    addr_b  = addr_a + span;
    // Twiddle table is sized for 512 points, so stride ignores N.
    tw_w    = {{TW_W{1'b0}}, pos} << (TW_W - int'(stage));
    tw_addr = tw_w[TW_W-1:0];
  end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Sequences in-place radix-2 DIT butterfly passes: read pairs, twiddle
// addresses, delayed write-back pairs and a done pulse.
module fft_stage_ctrl #(
  parameter int ADDR_W = fft_pkg::ADDR_W,
  parameter int TW_W   = fft_pkg::TW_W,
  parameter int BF_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [9:0]        N,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [TW_W-1:0]   tw_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b,
  output logic [3:0]        stage,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  import fft_pkg::*;

  localparam int PW = 2 * ADDR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-2:0] b_q, b_d;
  logic [ADDR_W-2:0] b_last_q, b_last_d;
  logic [3:0]        last_q, last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        stage_q, stage_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] rb_q, rb_d;
  logic [TW_W-1:0]   tw_q, tw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cfg_q, cfg_d;
  logic [PW-1:0]     pipe_q [BF_LAT];
  logic [PW-1:0]     pipe_d [BF_LAT];

  logic [3:0]        n_log2;
  logic [3:0]        gen_stage;
  logic [ADDR_W-1:0] gen_b;
  logic [ADDR_W-1:0] gen_a;
  logic [ADDR_W-1:0] gen_bb;
  logic [TW_W-1:0]   gen_tw;

  assign n_log2 = log2N(N);

  fft_bf_addr_gen #(
    .ADDR_W (ADDR_W),
    .TW_W   (TW_W)
  ) u_gen (
    .stage   (gen_stage),
    .b       (gen_b),
    .addr_a  (gen_a),
    .addr_b  (gen_bb),
    .tw_addr (gen_tw)
  );

  // Next-state logic; gen_* point at the pair issued next cycle.
  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    b_last_d  = b_last_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    busy_d    = busy_q;
    rd_en_d   = 1'b0;
    done_d    = 1'b0;
    cfg_d     = 1'b0;
    gen_stage = stage_q;
    gen_b     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_log2 != 4'd0) begin
            state_d  = S_LOAD;
            last_d   = n_log2 - 4'd1;
            b_last_d = (ADDR_W-1)'((N >> 1) - 10'd1);
            busy_d   = 1'b1;
          end else begin
            cfg_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        state_d   = S_RUN;
        stage_d   = '0;
        b_d       = '0;
        rd_en_d   = 1'b1;
        gen_stage = '0;
      end
      S_RUN: begin
        if (b_q == b_last_q) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          b_d     = b_q + (ADDR_W-1)'(1);
          rd_en_d = 1'b1;
          gen_b   = ADDR_W'(b_d);
        end
      end
      S_DRAIN: begin
        if (cnt_q == 4'(BF_LAT - 1)) begin
          if (stage_q == last_q) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d   = S_RUN;
            stage_d   = stage_q + 4'd1;
            b_d       = '0;
            rd_en_d   = 1'b1;
            gen_stage = stage_d;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ra_d = rd_en_d ? gen_a  : '0;
    rb_d = rd_en_d ? gen_bb : '0;
    tw_d = rd_en_d ? gen_tw : '0;
  end

  always_comb begin
    pipe_d[0] = {rd_en_q, ra_q, rb_q};
    for (int i = 1; i < BF_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      b_q      <= '0;
      b_last_q <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      stage_q  <= '0;
      rd_en_q  <= 1'b0;
      ra_q     <= '0;
      rb_q     <= '0;
      tw_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cfg_q    <= 1'b0;
      for (int i = 0; i < BF_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      b_last_q <= b_last_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      rd_en_q  <= rd_en_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      tw_q     <= tw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cfg_q    <= cfg_d;
      for (int i = 0; i < BF_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr_a = ra_q;
  assign rd_addr_b = rb_q;
  assign tw_addr   = tw_q;
  assign wr_en     = pipe_q[BF_LAT-1][PW-1];
  assign wr_addr_a = pipe_q[BF_LAT-1][PW-2:ADDR_W];
  assign wr_addr_b = pipe_q[BF_LAT-1][ADDR_W-1:0];
  assign stage     = stage_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl: per-cycle model compare,
// per-stage address scoreboard and literal timing pins.
module tb_fft_stage_ctrl;

  localparam int AW   = 9;
  localparam int TWW  = 8;
  localparam int LAT  = 4;
  localparam int MAXC = 8192;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [9:0]     N;
  logic           rd_en, wr_en, busy, done, cfg_err;
  logic [AW-1:0]  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [TWW-1:0] tw_addr;
  logic [3:0]     stage;

  fft_stage_ctrl #(.ADDR_W(AW), .TW_W(TWW), .BF_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .N         (N),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit e_rd [MAXC];
  bit e_wr [MAXC];
  bit e_busy [MAXC];
  bit e_done [MAXC];
  bit e_cfg [MAXC];
  int e_ra [MAXC];
  int e_rb [MAXC];
  int e_tw [MAXC];
  int e_wa [MAXC];
  int e_wb [MAXC];
  int e_st [MAXC];

  int n_chk = 0;
  int n_fail = 0;

  int rd_hit [16][512];
  int wr_hit [16][512];
  int done_cnt, done_cyc, wr_cnt, first_rd, cfg_cyc;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                 nm, cyc, act, req);
    end
  endtask

  function automatic int lg(input int n);
    case (n)
      64:      return 6;
      128:     return 7;
      256:     return 8;
      512:     return 9;
      default: return 0;
    endcase
  endfunction

  // Expected trace from the stage/butterfly rules in plain arithmetic.
  task automatic model_run(input int c0, input int n);
    int l, p, c, span, pos, a, dn;
    l = lg(n);
    p = n / 2 + LAT;
    for (int s = 0; s < l; s++) begin
      span = 1 << s;
      for (int b = 0; b < n / 2; b++) begin
        c   = c0 + 2 + s * p + b;
        pos = b % span;
        a   = (b / span) * 2 * span + pos;
        e_rd[c] = 1'b1;
        e_ra[c] = a;
        e_rb[c] = a + span;
        e_tw[c] = pos * (256 / span);
        e_st[c] = s;
        e_wr[c+LAT] = 1'b1;
        e_wa[c+LAT] = a;
        e_wb[c+LAT] = a + span;
      end
    end
    dn = c0 + 2 + l * p;
    for (int c2 = c0 + 1; c2 < dn; c2++) e_busy[c2] = 1'b1;
    e_done[dn] = 1'b1;
  endtask

  task automatic model_clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_rd[i] = 0; e_wr[i] = 0; e_busy[i] = 0;
      e_done[i] = 0; e_cfg[i] = 0;
      e_ra[i] = 0; e_rb[i] = 0; e_tw[i] = 0;
      e_wa[i] = 0; e_wb[i] = 0; e_st[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      chk("rd_en", int'(rd_en), int'(e_rd[cyc]));
      chk("rd_addr_a", int'(rd_addr_a), e_ra[cyc]);
      chk("rd_addr_b", int'(rd_addr_b), e_rb[cyc]);
      chk("tw_addr", int'(tw_addr), e_tw[cyc]);
      chk("wr_en", int'(wr_en), int'(e_wr[cyc]));
      chk("wr_addr_a", int'(wr_addr_a), e_wa[cyc]);
      chk("wr_addr_b", int'(wr_addr_b), e_wb[cyc]);
      chk("busy", int'(busy), int'(e_busy[cyc]));
      chk("done", int'(done), int'(e_done[cyc]));
      chk("cfg_err", int'(cfg_err), int'(e_cfg[cyc]));
      if (e_rd[cyc] || (!e_busy[cyc] && !e_done[cyc]))
        chk("stage", int'(stage), e_st[cyc]);
    end
    if (rd_en) begin
      rd_hit[stage][rd_addr_a]++;
      rd_hit[stage][rd_addr_b]++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (wr_en) begin
      wr_hit[stage][wr_addr_a]++;
      wr_hit[stage][wr_addr_b]++;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cfg_err) cfg_cyc = cyc;
  end

  task automatic go(input int n, output int c0);
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int s = 0; s < 16; s++)
      for (int i = 0; i < 512; i++) begin
        rd_hit[s][i] = 0;
        wr_hit[s][i] = 0;
      end
    done_cnt = 0; done_cyc = -1; wr_cnt = 0;
    first_rd = -1; cfg_cyc = -1;
    if (lg(n) != 0) model_run(c0, n);
    else e_cfg[c0+1] = 1'b1;
    start = 1'b1;
    N = 10'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    N = '0;
  endtask

  task automatic wait_run(input int n);
    repeat (2 + lg(n) * (n / 2 + LAT) + 4) @(posedge clk);
  endtask

  // Each index must be read and written exactly once per live stage.
  task automatic sb_check(input int n);
    int bad, req;
    bad = 0;
    for (int s = 0; s < 16; s++)
      for (int i = 0; i < 512; i++) begin
        req = (s < lg(n) && i < n) ? 1 : 0;
        if (rd_hit[s][i] != req) bad++;
        if (wr_hit[s][i] != req) bad++;
      end
    chk($sformatf("scoreboard_N%0d", n), bad, 0);
  endtask

  initial begin
    int c0, c, tsum;
    rst_n = 1'b0;
    start = 1'b0;
    N     = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    go(64, c0);
    wait_run(64);
    chk("n64_first_rd", first_rd - c0, 2);
    chk("n64_done_cyc", done_cyc - c0, 218);
    chk("n64_wr_cnt", wr_cnt, 192);
    chk("n64_done_cnt", done_cnt, 1);
    sb_check(64);

    go(128, c0);
    wait_run(128);
    chk("n128_done_cyc", done_cyc - c0, 2 + 7 * 68);
    sb_check(128);

    go(256, c0);
    wait_run(256);
    chk("n256_done_cyc", done_cyc - c0, 2 + 8 * 132);
    sb_check(256);

    go(512, c0);
    c = c0 + 2 + 8 * 260;
    chk("pin_s8_p0_a", e_ra[c], 0);
    chk("pin_s8_p0_b", e_rb[c], 256);
    chk("pin_s8_p0_tw", e_tw[c], 0);
    chk("pin_s8_p1_a", e_ra[c+1], 1);
    chk("pin_s8_p1_b", e_rb[c+1], 257);
    chk("pin_s8_p1_tw", e_tw[c+1], 1);
    tsum = 0;
    for (int i = 0; i < 256; i++) tsum += e_tw[c0+2+i];
    chk("pin_s0_tw_zero", tsum, 0);
    wait_run(512);
    chk("n512_done_cyc", done_cyc - c0, 2342);
    chk("n512_done_cnt", done_cnt, 1);
    sb_check(512);

    go(100, c0);
    repeat (4) @(posedge clk);
    chk("cfg_cyc", cfg_cyc - c0, 1);
    chk("cfg_no_done", done_cnt, 0);
    chk("cfg_no_rd", first_rd, -1);

    go(64, c0);
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    N = 10'd128;
    @(posedge clk);
    #1 start = 1'b0;
    N = '0;
    repeat (172) @(posedge clk);
    chk("busy_start_done_cyc", done_cyc - c0, 218);
    chk("busy_start_done_cnt", done_cnt, 1);
    sb_check(64);

    go(64, c0);
    repeat (114) @(posedge clk);
    #1;
    chk("pre_rst_stage", int'(stage), 3);
    rst_n = 1'b0;
    model_clear_from(cyc);
    #1;
    chk("rst_async_rd_en", int'(rd_en), 0);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_stage", int'(stage), 0);
    chk("rst_async_addr", int'(rd_addr_a), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (250) @(posedge clk);
    chk("rst_no_done", done_cnt, 0);

    go(128, c0);
    wait_run(128);
    chk("post_rst_done_cyc", done_cyc - c0, 2 + 7 * 68);
    chk("post_rst_done_cnt", done_cnt, 1);
    sb_check(128);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
